// File: rtl/uart_receiver.sv
// UART receiver: oversampled start detect, 2-of-3 majority bit sampling, optional parity,
// stop-bit check and a one-cycle data_valid strobe on each good byte.
module uart_receiver #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [5:0]            Prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
);

   localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e                state_q, state_d;
   logic [5:0]            edge_cnt_q, edge_cnt_d;
   logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [2:0]            samp_q, samp_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [5:0]            prescale_q, prescale_d;
   logic                  par_en_q, par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
   logic                  data_valid_q, data_valid_d;
   logic                  par_err_q, par_err_d;
   logic                  stp_err_q, stp_err_d;

   logic [5:0] half;
   logic       bit_tick;
   logic       bit_val;
   logic       exp_par;

   assign half     = {1'b0, prescale_q[5:1]};
   assign bit_tick = (edge_cnt_q == prescale_q - 6'd1);
   assign bit_val  = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
   assign exp_par  = par_typ_q ? ~^shift_q : ^shift_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= StIdle;
         edge_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         samp_q       <= '0;
         shift_q      <= '0;
         prescale_q   <= '0;
         par_en_q     <= 1'b0;
         par_typ_q    <= 1'b0;
         p_data_q     <= '0;
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         edge_cnt_q   <= edge_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         samp_q       <= samp_d;
         shift_q      <= shift_d;
         prescale_q   <= prescale_d;
         par_en_q     <= par_en_d;
         par_typ_q    <= par_typ_d;
         p_data_q     <= p_data_d;
         data_valid_q <= data_valid_d;
         par_err_q    <= par_err_d;
         stp_err_q    <= stp_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (!RX_IN) state_d = StStart;
         StStart:  if (bit_tick) state_d = bit_val ? StIdle : StData;
         StData:   if (bit_tick && bit_cnt_q == LastBit) state_d = par_en_q ? StParity : StStop;
         StParity: if (bit_tick) state_d = StStop;
         StStop:   if (bit_tick) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      edge_cnt_d   = edge_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      samp_d       = samp_q;
      shift_d      = shift_q;
      prescale_d   = prescale_q;
      par_en_d     = par_en_q;
      par_typ_d    = par_typ_q;
      p_data_d     = p_data_q;
      data_valid_d = 1'b0;
      par_err_d    = par_err_q;
      stp_err_d    = stp_err_q;

      if (state_q == StIdle) begin
         edge_cnt_d = '0;
         bit_cnt_d  = '0;
         if (!RX_IN) begin
            // The detect cycle is edge 0 of the start bit.
            edge_cnt_d = 6'd1;
            prescale_d = Prescale;
            par_en_d   = PAR_EN;
            par_typ_d  = PAR_TYP;
            par_err_d  = 1'b0;
            stp_err_d  = 1'b0;
         end
      end else begin
         edge_cnt_d = bit_tick ? 6'd0 : edge_cnt_q + 6'd1;
         if (edge_cnt_q == half - 6'd1) samp_d[0] = RX_IN;
         if (edge_cnt_q == half)        samp_d[1] = RX_IN;
         if (edge_cnt_q == half + 6'd1) samp_d[2] = RX_IN;
      end

      if (bit_tick) begin
         unique case (state_q)
            StData: begin
               shift_d[bit_cnt_q] = bit_val;
               bit_cnt_d = (bit_cnt_q == LastBit) ? '0 : bit_cnt_q + 1'b1;
            end
            StParity: if (bit_val != exp_par) par_err_d = 1'b1;
            StStop: begin
               if (!bit_val) begin
                  stp_err_d = 1'b1;
               end else if (!par_err_q) begin
                  p_data_d     = shift_q;
                  data_valid_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign P_DATA     = p_data_q;
   assign data_valid = data_valid_q;
   assign par_err    = par_err_q;
   assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: good frames across prescale/parity settings, parity and
// stop errors, a start glitch and a mid-frame reset.
module tb_uart_receiver;

   logic       CLK;
   logic       RST;
   logic       RX_IN;
   logic [5:0] Prescale;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [7:0] P_DATA;
   logic       data_valid;
   logic       par_err;
   logic       stp_err;

   int checks = 0;
   int errors = 0;
   int dv_cnt = 0;
   int dv_wide = 0;
   logic dv_prev = 1'b0;

   uart_receiver #(.DATA_WIDTH(8)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_IN      (RX_IN),
      .Prescale   (Prescale),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .P_DATA     (P_DATA),
      .data_valid (data_valid),
      .par_err    (par_err),
      .stp_err    (stp_err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Counts strobes and strobes lasting longer than one cycle.
   always @(negedge CLK) begin
      if (data_valid) dv_cnt++;
      if (data_valid && dv_prev) dv_wide++;
      dv_prev = data_valid;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      RX_IN = 1'b1;
      repeat (n) @(negedge CLK);
   endtask

   // Drives a full frame; returns at the negedge right after the stop bit's last sample edge.
   task automatic send_frame(input logic [7:0] data, input logic has_par, input logic par_bit,
                             input logic stop_bit, input int p);
      RX_IN = 1'b0;
      repeat (p) @(negedge CLK);
      for (int i = 0; i < 8; i++) begin
         RX_IN = data[i];
         repeat (p) @(negedge CLK);
      end
      if (has_par) begin
         RX_IN = par_bit;
         repeat (p) @(negedge CLK);
      end
      RX_IN = stop_bit;
      repeat (p) @(negedge CLK);
   endtask

   int         ps [3]    = '{32, 16, 8};
   logic       cfg_en [3] = '{1'b1, 1'b1, 1'b0};
   logic       cfg_typ [3] = '{1'b0, 1'b1, 1'b0};
   int         dv_base;
   logic [7:0] rst_data;

   initial begin
      RST      = 1'b1;
      RX_IN    = 1'b1;
      Prescale = 6'd32;
      PAR_EN   = 1'b1;
      PAR_TYP  = 1'b1;
      repeat (3) @(negedge CLK);
      check("rst_p_data", P_DATA, 8'h00);
      check("rst_dv", data_valid, 1'b0);
      check("rst_par_err", par_err, 1'b0);
      check("rst_stp_err", stp_err, 1'b0);
      RST = 1'b0;
      idle(4);

      // Odd parity, 0xBB has six ones so the parity bit is 1.
      send_frame(8'hBB, 1'b1, 1'b1, 1'b1, 32);
      check("f1_dv", data_valid, 1'b1);
      check("f1_p_data", P_DATA, 8'hBB);
      check("f1_par_err", par_err, 1'b0);
      check("f1_stp_err", stp_err, 1'b0);
      idle(3);
      check("f1_dv_low", data_valid, 1'b0);

      dv_base = dv_cnt;
      for (int i = 0; i < 3; i++) begin
         for (int c = 0; c < 3; c++) begin
            Prescale = 6'(ps[i]);
            PAR_EN   = cfg_en[c];
            PAR_TYP  = cfg_typ[c];
            send_frame(8'hBB, cfg_en[c], cfg_typ[c], 1'b1, ps[i]);
            check($sformatf("sweep_dv_p%0d_c%0d", ps[i], c), data_valid, 1'b1);
            check($sformatf("sweep_data_p%0d_c%0d", ps[i], c), P_DATA, 8'hBB);
         end
      end
      idle(3);
      check("sweep_dv_count", dv_cnt - dv_base, 9);

      // Even parity expects 0 for 0xBB; send 1.
      Prescale = 6'd16;
      PAR_EN   = 1'b1;
      PAR_TYP  = 1'b0;
      dv_base  = dv_cnt;
      send_frame(8'hBB, 1'b1, 1'b1, 1'b1, 16);
      check("perr_dv", data_valid, 1'b0);
      check("perr_par_err", par_err, 1'b1);
      check("perr_stp_err", stp_err, 1'b0);
      idle(3);
      check("perr_sticky", par_err, 1'b1);
      check("perr_dv_count", dv_cnt - dv_base, 0);

      // Config changes mid-frame must not matter; the frame runs with PAR_EN=0.
      PAR_EN  = 1'b0;
      dv_base = dv_cnt;
      RX_IN   = 1'b0;
      repeat (3) @(negedge CLK);
      check("serr_par_clr", par_err, 1'b0);
      PAR_EN  = 1'b1;
      repeat (13) @(negedge CLK);
      for (int i = 0; i < 8; i++) begin
         RX_IN = rst_data_bit(8'h5A, i);
         repeat (16) @(negedge CLK);
      end
      RX_IN = 1'b0;
      repeat (16) @(negedge CLK);
      RX_IN = 1'b1;
      check("serr_stp_err", stp_err, 1'b1);
      check("serr_par_err", par_err, 1'b0);
      check("serr_dv", data_valid, 1'b0);
      check("serr_p_data", P_DATA, 8'hBB);
      idle(3);
      check("serr_dv_count", dv_cnt - dv_base, 0);

      // Start glitch at Prescale=8: two low cycles are outvoted.
      Prescale = 6'd8;
      PAR_EN   = 1'b0;
      PAR_TYP  = 1'b0;
      dv_base  = dv_cnt;
      RX_IN    = 1'b0;
      repeat (2) @(negedge CLK);
      idle(12);
      check("glitch_par_err", par_err, 1'b0);
      check("glitch_stp_err", stp_err, 1'b0);
      check("glitch_dv_count", dv_cnt - dv_base, 0);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 8);
      check("glitch_next_dv", data_valid, 1'b1);
      check("glitch_next_data", P_DATA, 8'h3C);
      idle(3);

      // Reset in the middle of data bit 4.
      Prescale = 6'd16;
      rst_data = 8'hC3;
      dv_base  = dv_cnt;
      RX_IN    = 1'b0;
      repeat (16) @(negedge CLK);
      for (int i = 0; i < 4; i++) begin
         RX_IN = rst_data[i];
         repeat (16) @(negedge CLK);
      end
      RX_IN = rst_data[4];
      repeat (8) @(negedge CLK);
      RST   = 1'b1;
      RX_IN = 1'b1;
      @(negedge CLK);
      check("mrst_p_data", P_DATA, 8'h00);
      check("mrst_dv", data_valid, 1'b0);
      check("mrst_flags", {par_err, stp_err}, 2'b00);
      RST = 1'b0;
      idle(120);
      check("mrst_dv_count", dv_cnt - dv_base, 0);
      check("mrst_flags_after", {par_err, stp_err}, 2'b00);
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 16);
      check("mrst_next_dv", data_valid, 1'b1);
      check("mrst_next_data", P_DATA, 8'hA5);
      idle(3);
      check("dv_single_cycle", dv_wide, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   function automatic logic rst_data_bit(input logic [7:0] d, input int i);
      return d[i];
   endfunction

endmodule
